// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch/issue/retire sequencer that drives the PC register.
//               Optional PC_SEQ_MISALIGN_TRAP_EN turns misaligned branch
//               targets into traps and adds the misalign_fault output.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] TRAP_VECTOR = 32'h10000010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_value,
    output logic [31:0] pc_write_data,
    output logic        pc_write_enable,
    output logic        mem_read_req,
    output logic [31:0] mem_read_addr,
    input  logic        mem_ready,
    input  logic        mem_read_data_valid,
    input  logic [31:0] mem_read_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        trap_valid,
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    output logic        misalign_fault,
`endif
    output logic [31:0] trap_epc,
    output logic [63:0] instret
);

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        ISSUE      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] trap_epc_q, trap_epc_d;
    logic [63:0] instret_q, instret_d;
    logic [31:0] next_pc;
    logic        retire;
    logic        take_trap;
    logic        misalign;

`ifndef PC_SEQ_MISALIGN_TRAP_EN
    // Target low bits are dropped by alignment when misalign trapping is off.
    logic unused_bt_lsbs;
    assign unused_bt_lsbs = ^branch_target[1:0];
`endif

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        trap_epc_d = trap_epc_q;
        instret_d  = instret_q;
        retire     = 1'b0;
        take_trap  = 1'b0;
        misalign   = 1'b0;
        next_pc    = 32'd0;

        case (state_q)
            FETCH_REQ: begin
                if (mem_ready) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (mem_read_data_valid) begin
                    instr_d    = mem_read_data;
                    instr_pc_d = pc_value;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase

        // Branch/trap qualifiers only matter on the retire handshake.
        if (retire) begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            misalign  = branch_valid && !trap_valid && (branch_target[1:0] != 2'b00);
            take_trap = trap_valid || misalign;
`else
            take_trap = trap_valid;
`endif
            if (take_trap)
                next_pc = TRAP_VECTOR;
            else if (branch_valid)
                next_pc = {branch_target[31:2], 2'b00};
            else
                next_pc = pc_value + 32'd4;

            if (take_trap) trap_epc_d = instr_pc_q;
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH_REQ;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            trap_epc_q <= 32'd0;
            instret_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            trap_epc_q <= trap_epc_d;
            instret_q  <= instret_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign mem_read_req    = !reset && (state_q == FETCH_REQ);
    assign mem_read_addr   = mem_read_req ? pc_value : 32'd0;
    assign instr_valid     = !reset && (state_q == ISSUE);
    assign pc_write_enable = !reset && retire;
    assign pc_write_data   = pc_write_enable ? next_pc : 32'd0;
    assign instr           = instr_q;
    assign instr_pc        = instr_pc_q;
    assign trap_epc        = trap_epc_q;
    assign instret         = instret_q;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    assign misalign_fault  = !reset && misalign;
`endif

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The parameter list SHALL be: TRAP_VECTOR, 32'h10000010, PC value loaded on trap.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc_value  input  32  current PC register value.
REQ-005 pc_write_data  output  32  next PC value, to the PC register.
REQ-006 pc_write_enable  output  1  PC load strobe, to the PC register.
REQ-007 mem_read_req  output  1  instruction fetch request.
REQ-008 mem_read_addr  output  32  fetch address.
REQ-009 mem_ready  input  1  fetch request accepted this cycle.
REQ-010 mem_read_data_valid  input  1  fetch data returned this cycle.
REQ-011 mem_read_data  input  32  fetched instruction word.
REQ-012 instr_valid  output  1  instruction held for the execute stage.
REQ-013 instr_ready  input  1  execute stage accepts/retires the held instruction.
REQ-014 instr  output  32  held instruction word.
REQ-015 instr_pc  output  32  address of the held instruction.
REQ-016 branch_valid  input  1  retiring instruction redirects flow; qualified by the retire handshake.
REQ-017 branch_target  input  32  redirect target.
REQ-018 trap_valid  input  1  retiring instruction traps; qualified by the retire handshake.
REQ-019 trap_epc  output  32  PC of the last trapping instruction.
REQ-020 instret  output  64  retired-instruction count.

Function
REQ-021 The FSM SHALL have states FETCH_REQ, FETCH_WAIT and ISSUE, and SHALL enter FETCH_REQ on reset.
- FETCH_REQ: mem_read_req=1 and mem_read_addr=pc_value, both held stable until mem_ready=1; then go to FETCH_WAIT.
- FETCH_WAIT: on mem_read_data_valid=1, capture instr<=mem_read_data and instr_pc<=pc_value; then go to ISSUE.
- ISSUE: instr_valid=1. On instr_ready=1 (retire), pulse pc_write_enable=1 for exactly that cycle; then go to FETCH_REQ.
REQ-022 mem_read_data_valid SHALL be ignored in every state except FETCH_WAIT.
REQ-023 mem_read_req SHALL be 0 outside FETCH_REQ.
REQ-024 instr_valid SHALL be 0 outside ISSUE.
REQ-025 pc_write_enable SHALL be 0 outside the ISSUE retire cycle.
REQ-026 On retire, pc_write_data SHALL be selected by priority: trap_valid -> TRAP_VECTOR; else branch_valid -> branch_target (see REQ-033/034); else pc_value+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-027 branch_valid and trap_valid SHALL be ignored unless instr_valid&&instr_ready; simultaneous assertion SHALL resolve as trap.
REQ-028 On a trap retire, trap_epc SHALL load instr_pc on the next edge; otherwise trap_epc holds.
REQ-029 instret SHALL increment by 1 on every retire, including traps, and SHALL wrap from 2^64-1 to 0.
REQ-030 Minimum retire-to-retire spacing SHALL be 3 cycles (zero-wait memory: FETCH_REQ, FETCH_WAIT, ISSUE); instr and instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.

Reset
REQ-031 While reset=1, all outputs SHALL be 0 (trap_epc, instret, instr and instr_pc included), and the FSM SHALL enter FETCH_REQ on the first edge with reset=0.
REQ-032 Reset mid-fetch or mid-issue SHALL abandon the operation; any subsequent stale mem_read_data_valid SHALL be dropped unless the FSM is in FETCH_WAIT.

Configuration
REQ-033 With PC_SEQ_MISALIGN_TRAP_EN defined, a retire with branch_valid=1, trap_valid=0 and branch_target[1:0]!=0 SHALL be handled as a trap: pc_write_data=TRAP_VECTOR, trap_epc<=instr_pc, and output misalign_fault (1 bit) pulses high for that cycle.
REQ-034 Without PC_SEQ_MISALIGN_TRAP_EN, misalign_fault SHALL be absent and pc_write_data SHALL be {branch_target[31:2],2'b00}.

Verification
REQ-035 Reset release, pc_value=0x10000000, mem_ready=1, data 0x00000013 one cycle later, instr_ready=1 -> mem_read_addr=0x10000000; instr_valid on cycle 3; pc_write_data=0x10000004 with a one-cycle pc_write_enable; instret=1.
REQ-036 Retire with branch_valid=1, branch_target=0x10000100 -> pc_write_data=0x10000100; next mem_read_addr=0x10000100.
REQ-037 Retire with trap_valid=1 and branch_valid=1, instr_pc=0x10000008 -> pc_write_data=0x10000010; trap_epc=0x10000008.
REQ-038 mem_ready held 0 for 5 cycles, then mem_read_data_valid pulsed during FETCH_REQ -> addr stable, pulse ignored; instr_ready held 0 -> instr stable, no pc_write_enable.
REQ-039 branch_target=0x10000102, macro defined -> pc_write_data=0x10000010 and misalign_fault pulse; macro undefined -> pc_write_data=0x10000100.
REQ-040 Reset asserted in FETCH_WAIT, stale data_valid after release -> data dropped, fetch restarts at pc_value; instret=0.
